uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter (8N1, LSB first) among NUM_REQ byte producers.
- Accepts a byte from one requester, launches the transmitter with a one-cycle data-valid pulse, and holds the byte stable for the whole frame.
- Waits for the transmitter's done handshake to finish before granting again.
- Sits between the producer blocks (command responders, status reporters) and the single transmitter instance driving the serial pin.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GRANT_W, $clog2(NUM_REQ), width of grant index
WDOG_CYCLES, 65535, frame timeout in clocks (used only with the optional feature)

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Req_Valid  in  NUM_REQ  requester i has a byte; held until its ack
i_Req_Byte  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
o_Req_Ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i captured on the previous edge
o_Tx_DV  out  1  start pulse to transmitter
o_Tx_Byte  out  8  byte to transmitter, stable from launch until return to IDLE
i_Tx_Active  in  1  transmitter frame in progress
i_Tx_Done  in  1  transmitter done flag (high for 2 cycles after stop bit)
o_Grant_Id  out  GRANT_W  index of current or last served requester
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state=DRAIN, o_Req_Ack=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Grant_Id=0, o_Busy=1.
  - Round-robin pointer = 0, so requester 0 has highest priority.
- All outputs are registered.
- DRAIN: the transmitter has no reset and may still be mid-frame. Stay until i_Tx_Active=0 and i_Tx_Done=0, then go to IDLE.
- IDLE: if any i_Req_Valid is set, pick the first set bit scanning upward from the pointer, wrapping NUM_REQ-1 to 0. On that edge:
  - latch the byte into o_Tx_Byte;
  - set o_Grant_Id;
  - set the o_Req_Ack bit for one cycle;
  - set o_Tx_DV=1;
  - set pointer = winner+1 (mod NUM_REQ);
  - go to LAUNCH.
  - If no request, nothing changes.
- LAUNCH: lasts one cycle, with o_Tx_DV high and o_Req_Ack high. Next edge: clear both and go to WAIT_DONE.
- WAIT_DONE: stay until i_Tx_Done=1, then go to WAIT_CLR.
- WAIT_CLR: stay until i_Tx_Done=0 and i_Tx_Active=0, then go to IDLE. This guarantees the next o_Tx_DV is sampled while the transmitter is in its idle state.
- Latency: request seen in IDLE at edge N → ack and o_Tx_DV high during cycle N+1.
- Requesters:
  - Requester i must hold i_Req_Valid and its byte until it sees its ack bit.
  - It may drop valid, or present a new byte, in the cycle after the ack.
  - A valid request not yet acked may change its byte freely; the byte is sampled only at the grant edge.
- Simultaneous requests: exactly one is granted per frame. With all requesters continuously valid, grants go 0,1,2,3,0,…
- A valid bit dropped before its grant is simply not served.
- i_Tx_Done seen in IDLE or LAUNCH is ignored.
- Reset asserted mid-frame: outputs go to reset values immediately and the state goes to DRAIN. A pending requester is re-served later because no ack was given.

Optional Feature:
Macro UART_TX_SCHED_WDOG_EN.
- When defined:
  - 16-bit counter clears on entry to WAIT_DONE and increments each cycle in WAIT_DONE.
  - Reaching WDOG_CYCLES-1 forces the state to DRAIN and pulses output o_Wdog_Err (1 bit, reset 0) for one cycle.
  - The pointer still advances, so a stuck requester cannot monopolise the transmitter.
- When undefined: no counter, no o_Wdog_Err port, and WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_sched_pkg holds:
  - enum sched_state_t {S_DRAIN, S_IDLE, S_LAUNCH, S_WAIT_DONE, S_WAIT_CLR}, encoded 3-bit;
  - localparam UART_BYTE_W = 8.
- One sub-module, rr_pick: combinational round-robin selector with inputs request vector and pointer, and outputs one-hot grant, grant index and any_req.
- The scheduler FSM instantiates rr_pick once.

Test Plan:
- Single request: transmitter model CLKS_PER_BIT=4, reset released, Req_Valid=4'b0010, byte 8'hA5.
  - Ack=4'b0010 and Tx_DV both high one cycle after the request.
  - Serial line shows 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB first, stop).
  - o_Tx_Byte stays 8'hA5 until IDLE.
- All four valid continuously with bytes 8'h10..8'h13: grant order 0,1,2,3,0; bytes on the line 10,11,12,13,10; exactly one o_Tx_DV per frame.
- Ack handshake: requester 2 drops valid the cycle after its ack. No second frame for requester 2. Req 0 raised during req 2's frame is granted next, with Tx_DV two cycles after the transmitter's Done falls.
- Reset mid-frame: assert i_Reset during data bit 3.
  - Outputs go to zero and o_Busy=1.
  - No o_Tx_DV until the model's Done clears.
  - The pending requester is then served with a complete frame.
- WDOG: with UART_TX_SCHED_WDOG_EN and WDOG_CYCLES=100, a transmitter model that never raises Done yields o_Wdog_Err one pulse 100 cycles after launch. The next requester is granted after DRAIN.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
// Shared types and constants for the UART transmit scheduler.
//   sched_state_t : scheduler FSM state (3-bit encoding)
//   UART_BYTE_W   : width of one UART payload byte
package uart_sched_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    S_DRAIN     = 3'd0,
    S_IDLE      = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_CLR  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Scans the request vector upward
// starting at ptr, wrapping N-1 to 0, and reports the first set bit.
// Ports:
//   req     in  N  request vector
//   ptr     in  W  index with highest priority this round (0..N-1)
//   grant   out N  one-hot winner (all zero when no request)
//   idx     out W  index of winner (0 when no request)
//   any_req out 1  at least one request present
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any_req
);

  always_comb begin
    int   pos;
    logic found;
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = W'(pos);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler sharing one 8N1 UART transmitter among NUM_REQ
// byte producers. One byte is granted per frame; the byte is held on
// o_Tx_Byte from launch until the scheduler is idle again.
//
// Requester handshake: requester i raises i_Req_Valid[i] with its byte on
// i_Req_Byte[8i+7:8i] and holds both until o_Req_Ack[i] pulses. The byte is
// sampled only on the grant edge; the ack pulse (coincident with o_Tx_DV)
// means the byte was captured on the previous edge, and the requester may
// drop valid or present a new byte from the following cycle.
//
// Ports:
//   i_Clock, i_Reset        clock, asynchronous active-high reset
//   i_Req_Valid/i_Req_Byte  requester inputs
//   o_Req_Ack               one-cycle one-hot ack
//   o_Tx_DV/o_Tx_Byte       transmitter launch pulse and byte
//   i_Tx_Active/i_Tx_Done   transmitter status
//   o_Grant_Id              index of current or last served requester
//   o_Busy                  high in every state except IDLE
//   o_State                 current FSM state (debug)
//   o_Wdog_Err              frame timeout pulse (UART_TX_SCHED_WDOG_EN only)
//
// Optional feature: define UART_TX_SCHED_WDOG_EN to add a WAIT_DONE timeout
// of WDOG_CYCLES clocks that aborts to DRAIN and pulses o_Wdog_Err.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = $clog2(NUM_REQ)
`ifdef UART_TX_SCHED_WDOG_EN
  , parameter int WDOG_CYCLES = 65535
`endif
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [NUM_REQ-1:0]         i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
  output logic [NUM_REQ-1:0]         o_Req_Ack,
  output logic                       o_Tx_DV,
  output logic [UART_BYTE_W-1:0]     o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic [GRANT_W-1:0]         o_Grant_Id,
  output logic                       o_Busy,
  output sched_state_t               o_State
`ifdef UART_TX_SCHED_WDOG_EN
  , output logic                     o_Wdog_Err
`endif
);

  logic [GRANT_W-1:0] ptr;
  logic [NUM_REQ-1:0] pick_grant;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_any;

`ifdef UART_TX_SCHED_WDOG_EN
  logic [15:0] wdog_cnt;
`endif

  rr_pick #(
    .N (NUM_REQ),
    .W (GRANT_W)
  ) u_pick (
    .req     (i_Req_Valid),
    .ptr     (ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      // The transmitter has no reset, so always start by draining it.
      o_State    <= S_DRAIN;
      ptr        <= '0;
      o_Req_Ack  <= '0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= '0;
      o_Grant_Id <= '0;
      o_Busy     <= 1'b1;
`ifdef UART_TX_SCHED_WDOG_EN
      wdog_cnt   <= '0;
      o_Wdog_Err <= 1'b0;
`endif
    end else begin
      // Ack, launch and error are single-cycle pulses.
      o_Req_Ack  <= '0;
      o_Tx_DV    <= 1'b0;
`ifdef UART_TX_SCHED_WDOG_EN
      o_Wdog_Err <= 1'b0;
`endif
      case (o_State)
        S_DRAIN: begin
          if (!i_Tx_Active && !i_Tx_Done) begin
            o_State <= S_IDLE;
            o_Busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (pick_any) begin
            o_State    <= S_LAUNCH;
            o_Busy     <= 1'b1;
            o_Req_Ack  <= pick_grant;
            o_Tx_DV    <= 1'b1;
            o_Tx_Byte  <= i_Req_Byte[pick_idx*UART_BYTE_W +: UART_BYTE_W];
            o_Grant_Id <= pick_idx;
            ptr        <= (pick_idx == GRANT_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        S_LAUNCH: begin
          o_State <= S_WAIT_DONE;
`ifdef UART_TX_SCHED_WDOG_EN
          wdog_cnt <= '0;
`endif
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done) begin
            o_State <= S_WAIT_CLR;
`ifdef UART_TX_SCHED_WDOG_EN
          end else if (wdog_cnt + 16'd1 == 16'(WDOG_CYCLES - 1)) begin
            // Timeout: the pointer already moved past the stuck requester.
            o_State    <= S_DRAIN;
            o_Wdog_Err <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
`endif
          end
        end
        S_WAIT_CLR: begin
          // Return to IDLE only once the transmitter is fully idle, so the
          // next launch pulse cannot be missed.
          if (!i_Tx_Done && !i_Tx_Active) begin
            o_State <= S_IDLE;
            o_Busy  <= 1'b0;
          end
        end
        default: begin
          o_State <= S_DRAIN;
          o_Busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched with a behavioural 8N1 transmitter
// (4 clocks per bit, done high 2 cycles after the stop bit).
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam int N   = 4;
  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]   req_v;
  logic [7:0]     req_b [N];
  logic [8*N-1:0] req_bytes;
  logic [N-1:0]   ack;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           tx_active;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  sched_state_t   state_dbg;
`ifdef UART_TX_SCHED_WDOG_EN
  logic           wdog_err;
`endif

  always_comb begin
    req_bytes = '0;
    for (int i = 0; i < N; i++) req_bytes[8*i +: 8] = req_b[i];
  end

`ifdef UART_TX_SCHED_WDOG_EN
  uart_tx_sched #(.NUM_REQ(N), .WDOG_CYCLES(100)) dut (
`else
  uart_tx_sched #(.NUM_REQ(N)) dut (
`endif
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Req_Valid (req_v),
    .i_Req_Byte  (req_bytes),
    .o_Req_Ack   (ack),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_Grant_Id  (grant_id),
    .o_Busy      (busy),
    .o_State     (state_dbg)
`ifdef UART_TX_SCHED_WDOG_EN
    , .o_Wdog_Err (wdog_err)
`endif
  );

  // ---------------- transmitter model (no reset, like the real one) -------
  logic m_active;
  int   m_tick;
  int   m_done_cnt;
  bit   no_done;
  logic serial;
  int   bitn;

  initial begin
    m_active   = 1'b0;
    m_tick     = 0;
    m_done_cnt = 0;
    no_done    = 1'b0;
  end

  always @(posedge clk) begin
    if (m_done_cnt != 0) m_done_cnt <= m_done_cnt - 1;
    if (!m_active) begin
      if (tx_dv) begin
        m_active <= 1'b1;
        m_tick   <= 0;
      end
    end else if (m_tick == 10*CPB - 1) begin
      m_active <= 1'b0;
      if (!no_done) m_done_cnt <= 2;
    end else begin
      m_tick <= m_tick + 1;
    end
  end

  assign tx_active = m_active;
  assign tx_done   = (m_done_cnt != 0);

  // Serial line reads the live byte, so any instability during a frame shows.
  always_comb begin
    serial = 1'b1;
    bitn   = m_tick / CPB;
    if (m_active) begin
      if (bitn == 0)      serial = 1'b0;
      else if (bitn >= 9) serial = 1'b1;
      else                serial = tx_byte[bitn-1];
    end
  end

  // ---------------- scoreboard state ----------------
  int checks;
  int failures;
  int cyc;
  int dv_seen;
  int ptr_m;
  int wait_steps;
  int ack_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_dv === 1'b1) dv_seen++;
  endtask

  // Reference rule: first valid requester scanning upward from the pointer.
  function automatic int rr_expect(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst   = 1'b0;
    ptr_m = 0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300 && busy !== 1'b0; n++) step();
    chk("reach_idle", 32'(busy), 0);
  endtask

  // Wait for a grant, check it, apply the post-ack requester action
  // (mode 0 drop, 1 keep, 2 new byte), raise extra requests, and decode the
  // frame on the serial line.
  task automatic serve(input int w, input logic [7:0] b, input int mode,
                       input logic [N-1:0] raise);
    bit         got;
    int         dv0;
    logic [9:0] fr;
    logic [7:0] d;
    dv0        = dv_seen;
    got        = 1'b0;
    wait_steps = 0;
    fr         = '0;
    for (int n = 0; n < 400 && !got; n++) begin
      step();
      if (ack !== '0) begin
        got        = 1'b1;
        wait_steps = n + 1;
      end
    end
    chk("grant_timeout", 32'(got), 1);
    if (!got) return;
    ack_cyc = cyc;
    chk("ack_onehot", 32'(ack), 32'(1) << w);
    chk("launch_dv", 32'(tx_dv), 1);
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("launch_byte", 32'(tx_byte), 32'(b));
    chk("busy_launch", 32'(busy), 1);
    ptr_m = (w + 1) % N;
    step();
    chk("ack_clear", 32'(ack), 0);
    chk("dv_clear", 32'(tx_dv), 0);
    if (mode == 0)      req_v[w] = 1'b0;
    else if (mode == 2) req_b[w] = 8'($urandom_range(0, 255));
    for (int i = 0; i < N; i++) if (raise[i]) req_v[i] = 1'b1;
    for (int k = 0; k < 10*CPB; k++) begin
      if (k % CPB == CPB/2) begin
        fr[k/CPB] = serial;
        chk("byte_hold", 32'(tx_byte), 32'(b));
      end
      step();
    end
    for (int i = 0; i < 8; i++) d[i] = fr[i+1];
    chk("start_bit", 32'(fr[0]), 0);
    chk("stop_bit", 32'(fr[9]), 1);
    chk("line_data", 32'(d), 32'(b));
    chk("one_dv_per_frame", 32'(dv_seen - dv0), 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int         dv0;
    int         j;
    int         w;
    bit         got;
    logic [9:0] pat;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    dv_seen  = 0;
    ptr_m    = 0;
    rst      = 1'b1;
    req_v    = '0;
    for (int i = 0; i < N; i++) req_b[i] = 8'h00;

    // Reset values
    step();
    step();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dv", 32'(tx_dv), 0);
    chk("rst_byte", 32'(tx_byte), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_state", 32'(state_dbg), 32'(S_DRAIN));
    rst = 1'b0;

    // Single request: req1 = A5, ack/DV the cycle after the request.
    wait_idle();
    req_b[1] = 8'hA5;
    req_v    = 4'b0010;
    serve(1, 8'hA5, 0, '0);
    chk("single_latency", 32'(wait_steps), 1);
    wait_idle();
    chk("byte_after_frame", 32'(tx_byte), 32'h0000_00A5);
    pat = 10'b11_0100_1010; // line order bit0..bit9: 0,1,0,1,0,0,1,0,1,1
    chk("a5_pattern_start", 32'(pat[0]), 0);

    // All four continuously valid: grants 0,1,2,3,0.
    do_reset();
    wait_idle();
    for (int i = 0; i < N; i++) req_b[i] = 8'(8'h10 + i);
    req_v = 4'b1111;
    for (int k = 0; k < 5; k++) serve(k % 4, 8'(8'h10 + k % 4), 1, '0);
    req_v = '0;

    // Ack handshake: req2 drops after ack, req0 raised during its frame.
    wait_idle();
    req_b[2] = 8'($urandom_range(0, 255));
    req_b[0] = 8'($urandom_range(0, 255));
    req_v    = 4'b0100;
    serve(2, req_b[2], 0, 4'b0001);
    for (int n = 0; n < 50 && tx_done !== 1'b0; n++) step();
    chk("done_fell", 32'(tx_done), 0);
    serve(rr_expect(req_v, ptr_m), req_b[0], 0, '0);
    chk("dv_after_done", 32'(wait_steps), 2);

    // Reset mid-frame (during data bit 3), with req1 pending.
    wait_idle();
    req_b[3] = 8'($urandom_range(0, 255));
    req_v    = 4'b1000;
    got      = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      step();
      if (ack !== '0) got = 1'b1;
    end
    chk("midrst_ack", 32'(ack), 32'h8);
    step();
    req_v    = 4'b0010;
    req_b[1] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 17; k++) step();
    rst = 1'b1;
    #1;
    chk("midrst_ack0", 32'(ack), 0);
    chk("midrst_dv0", 32'(tx_dv), 0);
    chk("midrst_byte0", 32'(tx_byte), 0);
    chk("midrst_grant0", 32'(grant_id), 0);
    chk("midrst_busy", 32'(busy), 1);
    chk("midrst_state", 32'(state_dbg), 32'(S_DRAIN));
    step();
    step();
    rst   = 1'b0;
    ptr_m = 0;
    dv0   = dv_seen;
    for (int n = 0; n < 200 && tx_done !== 1'b1; n++) step();
    for (int n = 0; n < 50 && tx_done !== 1'b0; n++) step();
    chk("no_dv_in_drain", 32'(dv_seen - dv0), 0);
    serve(rr_expect(req_v, ptr_m), req_b[1], 0, '0);

    // Randomized rounds against the round-robin rule.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_v[i] = 1'b1;
            req_b[i] = 8'($urandom_range(0, 255));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req_b[i] = 8'($urandom_range(0, 255));
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        j        = int'($urandom_range(0, N-1));
        req_v[j] = 1'b0;
      end
      if (req_v == '0) begin
        j        = int'($urandom_range(0, N-1));
        req_v[j] = 1'b1;
        req_b[j] = 8'($urandom_range(0, 255));
      end
      w = rr_expect(req_v, ptr_m);
      serve(w, req_b[w], int'($urandom_range(0, 2)), '0);
    end
    req_v = '0;

`ifdef UART_TX_SCHED_WDOG_EN
    // Watchdog: transmitter never raises done.
    wait_idle();
    do_reset();
    wait_idle();
    no_done  = 1'b1;
    req_b[0] = 8'h5A;
    req_b[1] = 8'hC3;
    req_v    = 4'b0001;
    serve(0, 8'h5A, 0, 4'b0010);
    for (int n = 0; n < 300 && wdog_err !== 1'b1; n++) step();
    chk("wdog_fired", 32'(wdog_err), 1);
    chk("wdog_delay", 32'(cyc - ack_cyc), 100);
    step();
    chk("wdog_pulse", 32'(wdog_err), 0);
    no_done = 1'b0;
    serve(rr_expect(req_v, ptr_m), 8'hC3, 0, '0);
`endif

    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
